// File: rtl/z80fi_insn_collector.sv
// -----------------------------------------------------------------------------
// z80fi_insn_collector
//
// Gathers the bytes of each executed Z80 instruction from the core's fetch
// stream and emits one packed retirement record per retired instruction for
// the z80fi_insn_spec_* checker bank. Malformed fetch/retire sequences raise a
// sticky error that keeps the code of the first offence.
//
// Ports:
//   clk, reset_n     clock; asynchronous active-low reset
//   fetch_valid      an instruction byte was read this cycle
//   fetch_first      with fetch_valid: this byte starts a new instruction
//   fetch_byte       byte read
//   fetch_addr       address of fetch_byte
//   retire           core completed the instruction being collected
//   z80fi_valid      one-cycle pulse, record fields valid
//   z80fi_insn       instruction bytes, byte k at [8k+7:8k], unused bytes zero
//   z80fi_insn_len   byte count 1..4
//   z80fi_pc_rdata   address of byte 0
//   z80fi_order      retirement index, first record = 0, wraps
//   err, err_code    sticky error flag and first error code
//                    (01 abandoned, 10 overflow, 11 orphan)
// -----------------------------------------------------------------------------
module z80fi_insn_collector #(
  parameter int ORDER_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fetch_valid,
  input  logic               fetch_first,
  input  logic [7:0]         fetch_byte,
  input  logic [15:0]        fetch_addr,
  input  logic               retire,
  output logic               z80fi_valid,
  output logic [31:0]        z80fi_insn,
  output logic [2:0]         z80fi_insn_len,
  output logic [15:0]        z80fi_pc_rdata,
  output logic [ORDER_W-1:0] z80fi_order,
  output logic               err,
  output logic [1:0]         err_code
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_ABANDON  = 2'b01,
    ERR_OVERFLOW = 2'b10,
    ERR_ORPHAN   = 2'b11
  } err_t;

  state_t             state_q, state_d;
  logic [31:0]        buf_q, buf_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [15:0]        pc_q, pc_d;
  logic [ORDER_W-1:0] order_q;

  // Record as it stands after this cycle's continuation byte (if any); this is
  // what a same-cycle retire emits.
  logic [31:0]        acc_buf;
  logic [2:0]         acc_cnt;
  logic               emit;
  err_t               err_ev;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise a latch is inferred.
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    acc_buf = buf_q;
    acc_cnt = cnt_q;
    emit    = 1'b0;
    err_ev  = ERR_NONE;

    // Continuation byte (prefix, opcode, displacement or immediate).
    if (fetch_valid && !fetch_first) begin
      if (state_q == COLLECT) begin
        if (cnt_q < 3'd4) begin
          acc_buf[{cnt_q[1:0], 3'b000} +: 8] = fetch_byte;
          acc_cnt                            = cnt_q + 3'd1;
        end else begin
          err_ev = ERR_OVERFLOW;
        end
      end else begin
        err_ev = ERR_ORPHAN;
      end
    end

    buf_d = acc_buf;
    cnt_d = acc_cnt;

    // Retire closes the instruction held so far; a first byte arriving in the
    // same cycle belongs to the next instruction and is handled below.
    if (retire) begin
      if (state_q == COLLECT) begin
        emit    = 1'b1;
        state_d = IDLE;
      end else begin
        err_ev = ERR_ORPHAN;
      end
    end

    if (fetch_valid && fetch_first) begin
      if (state_q == COLLECT && !retire) begin
        err_ev = ERR_ABANDON;
      end
      buf_d   = {24'b0, fetch_byte};
      cnt_d   = 3'd1;
      pc_d    = fetch_addr;
      state_d = COLLECT;
    end
  end

  // ---------------------------------------------------------------------------
  // Working registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Record outputs: loaded on emission, held otherwise
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z80fi_valid    <= 1'b0;
      z80fi_insn     <= '0;
      z80fi_insn_len <= '0;
      z80fi_pc_rdata <= '0;
      z80fi_order    <= '0;
      order_q        <= '0;
    end else begin
      z80fi_valid <= emit;
      if (emit) begin
        z80fi_insn     <= acc_buf;
        z80fi_insn_len <= acc_cnt;
        z80fi_pc_rdata <= pc_q;
        z80fi_order    <= order_q;
        order_q        <= order_q + ORDER_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error: the first code wins until reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (!err && err_ev != ERR_NONE) begin
      err      <= 1'b1;
      err_code <= err_ev;
    end
  end

endmodule

// File: tb/tb_z80fi_insn_collector.sv
// -----------------------------------------------------------------------------
// Self-checking bench for z80fi_insn_collector: directed scenarios followed by
// randomized fetch/retire traffic, all compared against a queue-based
// instruction model evaluated once per clock.
// -----------------------------------------------------------------------------
module tb_z80fi_insn_collector;

  localparam int ORDER_W = 2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               fetch_valid;
  logic               fetch_first;
  logic [7:0]         fetch_byte;
  logic [15:0]        fetch_addr;
  logic               retire;
  logic               z80fi_valid;
  logic [31:0]        z80fi_insn;
  logic [2:0]         z80fi_insn_len;
  logic [15:0]        z80fi_pc_rdata;
  logic [ORDER_W-1:0] z80fi_order;
  logic               err;
  logic [1:0]         err_code;

  always #5 clk = ~clk;

  z80fi_insn_collector #(.ORDER_W(ORDER_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_valid    (fetch_valid),
    .fetch_first    (fetch_first),
    .fetch_byte     (fetch_byte),
    .fetch_addr     (fetch_addr),
    .retire         (retire),
    .z80fi_valid    (z80fi_valid),
    .z80fi_insn     (z80fi_insn),
    .z80fi_insn_len (z80fi_insn_len),
    .z80fi_pc_rdata (z80fi_pc_rdata),
    .z80fi_order    (z80fi_order),
    .err            (err),
    .err_code       (err_code)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the instruction in flight is a byte queue; records and
  // errors follow directly from the fetch/retire rules.
  // ---------------------------------------------------------------------------
  bit          m_busy;
  logic [7:0]  m_q[$];
  int          m_pc;
  int          m_order;
  bit          m_valid;
  logic [31:0] m_insn;
  int          m_len;
  int          m_rpc;
  int          m_rorder;
  bit          m_err;
  int          m_code;

  task automatic model_reset();
    m_busy = 0; m_q = {}; m_pc = 0; m_order = 0;
    m_valid = 0; m_insn = '0; m_len = 0; m_rpc = 0; m_rorder = 0;
    m_err = 0; m_code = 0;
  endtask

  task automatic model_step(input bit fv, input bit ff, input logic [7:0] b,
                            input logic [15:0] a, input bit ret);
    int code;
    code    = 0;
    m_valid = 0;
    if (fv && !ff) begin
      if (!m_busy)               code = 3;
      else if (m_q.size() >= 4)  code = 2;
      else                       m_q.push_back(b);
    end
    if (ret) begin
      if (m_busy) begin
        m_valid = 1;
        m_insn  = '0;
        foreach (m_q[i]) m_insn[8*i +: 8] = m_q[i];
        m_len    = m_q.size();
        m_rpc    = m_pc;
        m_rorder = m_order;
        m_order  = (m_order + 1) % (1 << ORDER_W);
        m_busy   = 0;
      end else begin
        code = 3;
      end
    end
    if (fv && ff) begin
      if (m_busy) code = 1;
      m_q    = {b};
      m_pc   = a;
      m_busy = 1;
    end
    if (code != 0 && !m_err) begin
      m_err  = 1;
      m_code = code;
    end
  endtask

  task automatic compare_all();
    check("valid",  z80fi_valid,    m_valid);
    check("insn",   z80fi_insn,     m_insn);
    check("len",    z80fi_insn_len, m_len);
    check("pc",     z80fi_pc_rdata, m_rpc);
    check("order",  z80fi_order,    m_rorder);
    check("err",    err,            m_err);
    check("code",   err_code,       m_code);
  endtask

  // One clock: drive, let the DUT sample, advance the model, compare.
  task automatic cycle(input bit fv, input bit ff, input logic [7:0] b,
                       input logic [15:0] a, input bit ret);
    fetch_valid = fv;
    fetch_first = ff;
    fetch_byte  = b;
    fetch_addr  = a;
    retire      = ret;
    @(posedge clk);
    model_step(fv, ff, b, a, ret);
    #1;
    compare_all();
  endtask

  // Reset asserted between edges; outputs must clear at once, release lands on
  // a falling edge.
  task automatic do_reset(input string tag);
    fetch_valid = 0; fetch_first = 0; fetch_byte = '0; fetch_addr = '0; retire = 0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_valid"}, z80fi_valid,    0);
    check({tag, "_insn"},  z80fi_insn,     0);
    check({tag, "_len"},   z80fi_insn_len, 0);
    check({tag, "_pc"},    z80fi_pc_rdata, 0);
    check({tag, "_order"}, z80fi_order,    0);
    check({tag, "_err"},   err,            0);
    check({tag, "_code"},  err_code,       0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(0, 0, 8'h00, 16'h0000, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    fetch_valid = 0; fetch_first = 0; fetch_byte = '0; fetch_addr = '0; retire = 0;
    model_reset();
    #7;
    do_reset("rst");

    // LD (IX+5),B
    cycle(1, 1, 8'hDD, 16'h1000, 0);
    cycle(1, 0, 8'h70, 16'h1001, 0);
    cycle(1, 0, 8'h05, 16'h1002, 1);
    check("ld_valid", z80fi_valid, 1);
    check("ld_insn",  z80fi_insn, 32'h000570DD);
    check("ld_len",   z80fi_insn_len, 3);
    check("ld_pc",    z80fi_pc_rdata, 16'h1000);
    check("ld_order", z80fi_order, 0);
    check("ld_err",   err, 0);
    cycle(0, 0, 8'h00, 16'h0000, 0);
    check("ld_pulse", z80fi_valid, 0);

    // NOP retired together with the next first byte
    do_reset("rst_b2b");
    cycle(1, 1, 8'h00, 16'h2000, 0);
    cycle(1, 1, 8'h3E, 16'h2001, 1);
    check("b2b0_insn",  z80fi_insn, 32'h0);
    check("b2b0_len",   z80fi_insn_len, 1);
    check("b2b0_pc",    z80fi_pc_rdata, 16'h2000);
    check("b2b0_order", z80fi_order, 0);
    cycle(1, 0, 8'h42, 16'h2002, 1);
    check("b2b1_insn",  z80fi_insn, 32'h0000423E);
    check("b2b1_len",   z80fi_insn_len, 2);
    check("b2b1_pc",    z80fi_pc_rdata, 16'h2001);
    check("b2b1_order", z80fi_order, 1);
    check("b2b_err",    err, 0);

    // Overflow: fifth byte dropped
    do_reset("rst_ovf");
    cycle(1, 1, 8'hDD, 16'h3000, 0);
    cycle(1, 0, 8'hCB, 16'h3001, 0);
    cycle(1, 0, 8'h05, 16'h3002, 0);
    cycle(1, 0, 8'h46, 16'h3003, 0);
    cycle(1, 0, 8'h99, 16'h3004, 0);
    cycle(0, 0, 8'h00, 16'h0000, 1);
    check("ovf_err",  err, 1);
    check("ovf_code", err_code, 2'b10);
    check("ovf_insn", z80fi_insn, 32'h4605CBDD);
    check("ovf_len",  z80fi_insn_len, 4);

    // Orphan byte and orphan retire; a later abandon keeps code 11
    do_reset("rst_orph");
    cycle(1, 0, 8'h12, 16'h4000, 0);
    cycle(0, 0, 8'h00, 16'h0000, 1);
    check("orph_valid", z80fi_valid, 0);
    check("orph_err",   err, 1);
    check("orph_code",  err_code, 2'b11);
    cycle(1, 1, 8'hFD, 16'h4001, 0);
    cycle(1, 1, 8'h00, 16'h4002, 0);
    check("orph_keep",  err_code, 2'b11);

    // Abandon, then asynchronous reset while two bytes are held
    do_reset("rst_abn");
    cycle(1, 1, 8'hFD, 16'h5000, 0);
    cycle(1, 1, 8'h00, 16'h5001, 0);
    check("abn_code", err_code, 2'b01);
    cycle(1, 0, 8'h11, 16'h5002, 0);
    do_reset("rst_mid");
    cycle(0, 0, 8'h00, 16'h0000, 1);
    check("mid_norec", z80fi_valid, 0);

    // Order wrap with back-to-back single-byte instructions
    do_reset("rst_wrap");
    cycle(1, 1, 8'h00, 16'h6000, 0);
    for (int i = 1; i < 5; i++) begin
      cycle(1, 1, 8'h00, 16'(16'h6000 + i), 1);
      check("wrap_valid", z80fi_valid, 1);
      check("wrap_order", z80fi_order, i - 1);
    end
    cycle(0, 0, 8'h00, 16'h0000, 1);
    check("wrap_valid", z80fi_valid, 1);
    check("wrap_order", z80fi_order, 0);

    // Randomized traffic, periodically reset so every error code gets a turn
    for (int blk = 0; blk < 12; blk++) begin
      do_reset("rst_rand");
      for (int n = 0; n < 250; n++) begin
        bit fv, ff, ret;
        fv  = ($urandom_range(0, 9) < 7);
        ff  = fv ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1) == 1;
        ret = ($urandom_range(0, 9) < 3);
        cycle(fv, ff, 8'($urandom), 16'($urandom), ret);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z80fi_insn_collector.md
# z80fi_insn_collector

Assembles the bytes of each executed Z80 instruction, fetched from the core's bus-side fetch stream, into one packed retirement record. It emits the z80fi_valid / z80fi_insn / z80fi_insn_len / z80fi_pc_rdata fields consumed by the per-instruction z80fi_insn_spec_* checkers. It sits between the core's fetch/retire strobes and the spec-checker bank, and raises a sticky error on malformed byte/retire sequences.

## Interface
Parameters:
- ORDER_W, 16, width of retirement order counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_valid  in  1  an instruction byte (opcode, prefix, displacement or immediate) was read this cycle.
- fetch_first  in  1  qualifies fetch_valid: this byte starts a new instruction (first M1).
- fetch_byte  in  8  byte read.
- fetch_addr  in  16  address of fetch_byte.
- retire  in  1  core completed the instruction currently being collected.
- z80fi_valid  out  1  one-cycle pulse: record fields are valid.
- z80fi_insn  out  32  instruction bytes in fetch order; byte k at [8k+7:8k]; unused bytes zero.
- z80fi_insn_len  out  3  byte count, 1..4.
- z80fi_pc_rdata  out  16  fetch_addr of byte 0.
- z80fi_order  out  ORDER_W  retirement index, first record = 0.
- err  out  1  sticky error flag.
- err_code  out  2  code of first error: 01 abandoned, 10 overflow, 11 orphan.

## Operation
- States: IDLE (nothing collected), COLLECT (≥1 byte held). Working registers: buf[31:0], cnt[2:0], pc[15:0].
- fetch_first has no effect without fetch_valid.
- fetch_valid && fetch_first, any state: buf <= {24'b0, fetch_byte}, cnt <= 1, pc <= fetch_addr, go COLLECT.
- fetch_valid && !fetch_first in COLLECT, cnt<4: buf[8*cnt +: 8] <= fetch_byte, cnt <= cnt+1.
- Same with cnt==4: byte dropped, error 10.
- fetch_valid && !fetch_first in IDLE: byte dropped, error 11.
- retire in COLLECT: emit record from buf/cnt/pc, including any non-first byte accepted in the same cycle. Go IDLE unless a fetch_first arrives in the same cycle.
- retire && fetch_valid && fetch_first, same cycle: the retire belongs to the old instruction. Emit the old record (excluding the new byte), then start the new instruction. No error.
- fetch_valid && fetch_first in COLLECT without retire: old instruction discarded, error 01, new one started.
- retire in IDLE: no record, error 11.
- Emission: z80fi_insn <= buf, z80fi_insn_len <= cnt, z80fi_pc_rdata <= pc, z80fi_order <= order_cnt, then order_cnt++ (wraps modulo 2^ORDER_W).
- Record outputs hold between emissions.
- Errors: err sets on the first error and err_code latches that code. Later errors do not change err_code. Both clear only on reset. Errors never block collection or emission.

## Timing
- Reset (async assert, sync release) clears all outputs and working registers to 0 and puts the block in IDLE.
- Reset mid-COLLECT discards the partial instruction; no record.
- All outputs registered.
- retire sampled at edge N → z80fi_valid high for cycle N+1 only, with fields valid in the same cycle.
- Back-to-back retires on consecutive cycles (single-byte instructions) give consecutive valid pulses.
- Throughput: one fetch byte per cycle and one record per cycle.
- z80fi_valid never high for two cycles from one retire.

## Test plan
- LD (IX+5),B: DD@0x1000 first, 70@0x1001, 05@0x1002, retire with last byte → next cycle valid=1, insn=0x000570DD, len=3, pc=0x1000, order=0, err=0.
- Back-to-back: NOP (00@0x2000) then retire together with fetch_first of 3E@0x2001, then 42, then retire → records {insn=0x00000000, len=1, pc=0x2000, order=0} and {0x0000423E, len=2, pc=0x2001, order=1}.
- Overflow: DD CB 05 46 then extra byte 99, then retire → err=1, err_code=10, record insn=0x4605CBDD, len=4.
- Orphan: after reset, non-first byte 12 and then retire in IDLE → no valid pulse, err=1, err_code=11. A later abandon leaves err_code=11.
- Abandon, then reset mid-collect: FD first, then fetch_first 00 without retire → err_code=01. Assert reset_n=0 asynchronously after 2 bytes → all outputs 0 immediately, no record after release.
- Order wrap with ORDER_W=2: five single-byte retirements → order sequence 0,1,2,3,0.
